// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game response path.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CHECK,
        RELEASE,
        PASS,
        FAIL
    } chk_state_t;

    typedef logic [1:0] colour_t;

    localparam logic [3:0]  MAX_LEVEL  = 4'd9;
    localparam int unsigned CYC_PER_MS = 50_000;

    // Index of the set bit of a one-hot button vector.
    function automatic colour_t encode_onehot(input logic [3:0] v);
        colour_t idx;
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[i]) idx = colour_t'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 one-hot decoder.
module decoder_2_4 (
    input  logic [1:0] a_i,
    output logic [3:0] y_o
);

    // Binary index to one-hot.
    always_comb begin
        y_o = '0;
        case (a_i)
            2'd0:    y_o = 4'b0001;
            2'd1:    y_o = 4'b0010;
            2'd2:    y_o = 4'b0100;
            default: y_o = 4'b1000;
        endcase
    end

endmodule

// File: rtl/input_checker_button_debouncer.sv
// Two-flop synchroniser plus stability counter for a 4-bit button vector.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYC = 20 * 50_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] btn_i,
    output logic [3:0] db_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchroniser, debounced vector and stability counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count while the synchronised value differs from db; any return to db restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) db_d = sync2_q;
            else                                cnt_d = cnt_q + CW'(1);
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/input_checker.sv
// Player-response checker: debounces buttons, compares each press with memory,
// reports pass/fail to the game FSM and echoes the held button on led_out.
module input_checker #(
    parameter int unsigned CYC_PER_MS  = simon_pkg::CYC_PER_MS,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned TIMEOUT_MS  = 5_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] level,
    input  logic [3:0] btn,
    input  logic [1:0] expected,
    output logic [3:0] addr,
    output logic       pass,
    output logic       fail,
    output logic [9:0] led_out
);

    localparam int unsigned DEBOUNCE_CYC = DEBOUNCE_MS * CYC_PER_MS;
    localparam int unsigned TIMEOUT_CYC  = TIMEOUT_MS * CYC_PER_MS;
    localparam int unsigned TW           = $clog2(TIMEOUT_CYC + 1);

    simon_pkg::chk_state_t state_q, state_d;
    simon_pkg::colour_t    sel_q, sel_d;
    logic [3:0]            addr_q, addr_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [3:0]            db;
    logic [3:0]            sel_onehot;

    button_debouncer #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debouncer (
        .clk_i (clk),
        .rst_i (reset),
        .btn_i (btn),
        .db_o  (db)
    );

    decoder_2_4 u_sel_decoder (
        .a_i (sel_q),
        .y_o (sel_onehot)
    );

    // FSM state, step index, timeout timer and latched selection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= simon_pkg::IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic; dropping enable aborts from any state.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        if (!enable) begin
            state_d = simon_pkg::IDLE;
            addr_d  = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                simon_pkg::IDLE: begin
                    addr_d  = '0;
                    timer_d = '0;
                    // A button still held from an aborted round must be released first.
                    if (level <= simon_pkg::MAX_LEVEL && db == '0) state_d = simon_pkg::WAIT;
                end
                simon_pkg::WAIT: begin
                    timer_d = timer_q + TW'(1);
                    if (db != '0) begin
                        if (simon_pkg::is_onehot(db)) begin
                            sel_d   = simon_pkg::encode_onehot(db);
                            state_d = simon_pkg::CHECK;
                        end else begin
                            state_d = simon_pkg::FAIL;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        state_d = simon_pkg::FAIL;
                    end
                end
                simon_pkg::CHECK: begin
                    state_d = (sel_q != expected) ? simon_pkg::FAIL : simon_pkg::RELEASE;
                end
                simon_pkg::RELEASE: begin
                    if (db == '0) begin
                        timer_d = '0;
                        if (addr_q == level) begin
                            state_d = simon_pkg::PASS;
                        end else begin
                            addr_d  = addr_q + 4'd1;
                            state_d = simon_pkg::WAIT;
                        end
                    end
                end
                simon_pkg::PASS, simon_pkg::FAIL: begin
                    state_d = state_q;
                end
                default: state_d = simon_pkg::IDLE;
            endcase
        end
    end

    assign addr    = addr_q;
    assign pass    = (state_q == simon_pkg::PASS);
    assign fail    = (state_q == simon_pkg::FAIL);
    assign led_out = (state_q == simon_pkg::CHECK || state_q == simon_pkg::RELEASE)
                     ? {6'd0, sel_onehot} : '0;

endmodule

// File: tb/tb_input_checker.sv
// Directed self-checking bench for input_checker (1 cycle per ms, 4 ms debounce, 50 ms timeout).
module tb_input_checker;

    localparam int unsigned CYC = 1;
    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 50;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] level  = 4'd2;
    logic [3:0] btn    = '0;
    logic [1:0] expected;
    logic [3:0] addr;
    logic       pass;
    logic       fail;
    logic [9:0] led_out;

    logic [1:0] mem [16];
    int checks   = 0;
    int failures = 0;
    logic pass_seen;

    always #5 clk = ~clk;

    assign expected = mem[addr];

    input_checker #(
        .CYC_PER_MS  (CYC),
        .DEBOUNCE_MS (DEB),
        .TIMEOUT_MS  (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .level    (level),
        .btn      (btn),
        .expected (expected),
        .addr     (addr),
        .pass     (pass),
        .fail     (fail),
        .led_out  (led_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd0;

        // Reset state
        cycles(2);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_fail", 32'(fail), 32'd0);
        check_eq("rst_led", 32'(led_out), 32'd0);
        reset = 1'b0;
        cycles(1);

        // 1: clean round, presses 1,3,0
        enable = 1'b1; cycles(1);
        btn = 4'b0010; cycles(9);
        check_eq("t1_led0", 32'(led_out), 32'h002);
        check_eq("t1_addr0", 32'(addr), 32'd0);
        btn = 4'b0000; cycles(10);
        check_eq("t1_addr1", 32'(addr), 32'd1);
        btn = 4'b1000; cycles(9);
        check_eq("t1_led1", 32'(led_out), 32'h008);
        btn = 4'b0000; cycles(10);
        check_eq("t1_addr2", 32'(addr), 32'd2);
        btn = 4'b0001; cycles(9);
        check_eq("t1_led2", 32'(led_out), 32'h001);
        check_eq("t1_nopass_yet", 32'(pass), 32'd0);
        btn = 4'b0000; cycles(10);
        check_eq("t1_pass", 32'(pass), 32'd1);
        check_eq("t1_fail", 32'(fail), 32'd0);
        check_eq("t1_addr_end", 32'(addr), 32'd2);

        // 2: wrong press on step 1
        enable = 1'b0; cycles(1);
        check_eq("t2_abort_clear", 32'(pass), 32'd0);
        enable = 1'b1; cycles(1);
        btn = 4'b0010; cycles(9);
        btn = 4'b0000; cycles(10);
        check_eq("t2_addr1", 32'(addr), 32'd1);
        btn = 4'b0100; cycles(7);
        check_eq("t2_check_led", 32'(led_out), 32'h004);
        check_eq("t2_check_nofail", 32'(fail), 32'd0);
        cycles(1);
        check_eq("t2_fail", 32'(fail), 32'd1);
        check_eq("t2_fail_led", 32'(led_out), 32'd0);
        check_eq("t2_fail_addr", 32'(addr), 32'd1);
        btn = 4'b0000; cycles(10);
        check_eq("t2_fail_sticky", 32'(fail), 32'd1);
        check_eq("t2_nopass", 32'(pass), 32'd0);

        // 3: bouncing btn[2] accepted once
        mem[0] = 2'd2;
        enable = 1'b0; cycles(2);
        enable = 1'b1; cycles(1);
        for (int k = 0; k < 5; k++) begin
            btn = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            cycles(2);
        end
        btn = 4'b0100; cycles(10);
        btn = 4'b0000; cycles(10);
        check_eq("t3_addr", 32'(addr), 32'd1);
        check_eq("t3_fail", 32'(fail), 32'd0);
        check_eq("t3_pass", 32'(pass), 32'd0);
        mem[0] = 2'd1;

        // 4: timeout
        enable = 1'b0; cycles(2);
        enable = 1'b1;
        pass_seen = 1'b0;
        for (int k = 0; k < 45; k++) begin
            cycles(1);
            if (pass) pass_seen = 1'b1;
        end
        check_eq("t4_early_fail", 32'(fail), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cycles(1);
            if (pass) pass_seen = 1'b1;
        end
        check_eq("t4_timeout_fail", 32'(fail), 32'd1);
        check_eq("t4_pass_never", 32'(pass_seen), 32'd0);

        // 5: multi-press, then out-of-range level
        enable = 1'b0; cycles(2);
        enable = 1'b1; cycles(1);
        btn = 4'b0101; cycles(10);
        check_eq("t5_multi_fail", 32'(fail), 32'd1);
        check_eq("t5_multi_pass", 32'(pass), 32'd0);
        btn = 4'b0000; enable = 1'b0; level = 4'd12; cycles(10);
        enable = 1'b1; cycles(5);
        btn = 4'b0010; cycles(10);
        check_eq("t5_lvl12_led", 32'(led_out), 32'd0);
        check_eq("t5_lvl12_pass", 32'(pass), 32'd0);
        check_eq("t5_lvl12_fail", 32'(fail), 32'd0);
        check_eq("t5_lvl12_addr", 32'(addr), 32'd0);
        btn = 4'b0000; cycles(10);
        enable = 1'b0; level = 4'd2; cycles(2);

        // 6: abort with held button, re-enable, async reset mid-RELEASE
        enable = 1'b1; cycles(1);
        btn = 4'b0010; cycles(9);
        btn = 4'b0000; cycles(10);
        check_eq("t6_addr1", 32'(addr), 32'd1);
        btn = 4'b1000; cycles(9);
        check_eq("t6_held_led", 32'(led_out), 32'h008);
        enable = 1'b0; cycles(1);
        check_eq("t6_abort_led", 32'(led_out), 32'd0);
        check_eq("t6_abort_addr", 32'(addr), 32'd0);
        check_eq("t6_abort_flags", 32'({pass, fail}), 32'd0);
        enable = 1'b1; cycles(15);
        check_eq("t6_held_no_press", 32'(led_out), 32'd0);
        check_eq("t6_held_addr", 32'(addr), 32'd0);
        btn = 4'b0000; cycles(10);
        btn = 4'b0010; cycles(9);
        check_eq("t6_repress_led", 32'(led_out), 32'h002);
        btn = 4'b0000; cycles(10);
        check_eq("t6_repress_addr", 32'(addr), 32'd1);
        btn = 4'b1000; cycles(9);
        btn = 4'b1001; cycles(10);
        check_eq("t6_second_ignored", 32'(led_out), 32'h008);
        check_eq("t6_second_nofail", 32'(fail), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_areset_led", 32'(led_out), 32'd0);
        check_eq("t6_areset_addr", 32'(addr), 32'd0);
        check_eq("t6_areset_flags", 32'({pass, fail}), 32'd0);
        cycles(2);
        reset = 1'b0; btn = 4'b0000;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
